// File: rtl/dmem_bus_if.sv
// Core data-port bus: strobes, word address and store data from the core,
// registered load data back from the memory/I/O unit.
interface dmem_bus_if #(
  parameter int WIDTH = 32
);
  logic             memread;
  logic             memwrite;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] memdata;

  modport master (
    output memread,
    output memwrite,
    output adr,
    output writedata,
    input  memdata
  );

  modport slave (
    input  memread,
    input  memwrite,
    input  adr,
    input  writedata,
    output memdata
  );
endinterface

// File: rtl/dmem_bus.sv
// Data-memory bus unit: word RAM plus memory-mapped LED, switch and compare
// timer registers, with one-edge registered read data and read-before-write.
module dmem_bus #(
  parameter int WIDTH   = 32,
  parameter int RAMBITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  dmem_bus_if.slave   bus,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        tmr_irq
);

  localparam int DEPTH = 1 << RAMBITS;

  localparam logic [WIDTH-1:0] LED_ADR  = WIDTH'(32'hFFFF_0000);
  localparam logic [WIDTH-1:0] SW_ADR   = WIDTH'(32'hFFFF_0004);
  localparam logic [WIDTH-1:0] TCNT_ADR = WIDTH'(32'hFFFF_0008);
  localparam logic [WIDTH-1:0] TCMP_ADR = WIDTH'(32'hFFFF_000C);
  localparam logic [WIDTH-1:0] TCTL_ADR = WIDTH'(32'hFFFF_0010);

  logic [WIDTH-1:0]   ram [DEPTH];
  logic [WIDTH-1:0]   ram_rd_reg;
  logic               sel_ram_reg;
  logic [WIDTH-1:0]   io_rd_reg;

  logic [15:0]        led_reg;
  logic [15:0]        sw_meta_reg;
  logic [15:0]        sw_sync_reg;
  logic [WIDTH-1:0]   tcnt_reg;
  logic [WIDTH-1:0]   tcmp_reg;
  logic               en_reg;
  logic               match_reg;

  logic [WIDTH-1:0]   word_adr;
  logic               is_ram;
  logic [RAMBITS-1:0] ram_idx;
  logic               wr_led;
  logic               wr_tcnt;
  logic               wr_tcmp;
  logic               wr_tctl;
  logic               tmr_hit;
  logic [WIDTH-1:0]   tcnt_next;
  logic               match_next;
  logic [WIDTH-1:0]   io_rdata;
  logic               unused_adr_lsbs;

  // Byte lane bits never participate in decode; every access is a word access.
  assign word_adr        = {bus.adr[WIDTH-1:2], 2'b00};
  assign unused_adr_lsbs = &{1'b0, bus.adr[1:0]};
  assign is_ram          = (bus.adr[WIDTH-1:RAMBITS+2] == '0);
  assign ram_idx         = bus.adr[RAMBITS+1:2];

  assign wr_led  = bus.memwrite && (word_adr == LED_ADR);
  assign wr_tcnt = bus.memwrite && (word_adr == TCNT_ADR);
  assign wr_tcmp = bus.memwrite && (word_adr == TCMP_ADR);
  assign wr_tctl = bus.memwrite && (word_adr == TCTL_ADR);

  // Core write to TCNT beats the count step; a match beats write-1-clear.
  always_comb begin
    tmr_hit    = en_reg && (tcnt_reg == tcmp_reg);
    tcnt_next  = tcnt_reg;
    if (en_reg) begin
      tcnt_next = tmr_hit ? '0 : tcnt_reg + WIDTH'(1);
    end
    if (wr_tcnt) begin
      tcnt_next = bus.writedata;
    end
    match_next = match_reg;
    if (wr_tctl && bus.writedata[1]) begin
      match_next = 1'b0;
    end
    if (tmr_hit) begin
      match_next = 1'b1;
    end
  end

  always_comb begin
    io_rdata = '0;
    case (word_adr)
      LED_ADR:  io_rdata = WIDTH'(led_reg);
      SW_ADR:   io_rdata = WIDTH'(sw_sync_reg);
      TCNT_ADR: io_rdata = tcnt_reg;
      TCMP_ADR: io_rdata = tcmp_reg;
      TCTL_ADR: io_rdata = WIDTH'({match_reg, en_reg});
      default:  io_rdata = '0;
    endcase
  end

  // RAM kept reset-free so it maps onto block RAM; writes are blocked while
  // reset is held so an interrupted store never lands.
  always_ff @(posedge clk) begin
    if (bus.memwrite && is_ram && reset) begin
      ram[ram_idx] <= bus.writedata;
    end
    if (bus.memread && is_ram) begin
      ram_rd_reg <= ram[ram_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_ram_reg <= 1'b0;
      io_rd_reg   <= '0;
      led_reg     <= '0;
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
      tcnt_reg    <= '0;
      tcmp_reg    <= '1;
      en_reg      <= 1'b0;
      match_reg   <= 1'b0;
    end else begin
      sw_meta_reg <= sw;
      sw_sync_reg <= sw_meta_reg;
      tcnt_reg    <= tcnt_next;
      match_reg   <= match_next;
      if (wr_led) begin
        led_reg <= bus.writedata[15:0];
      end
      if (wr_tcmp) begin
        tcmp_reg <= bus.writedata;
      end
      if (wr_tctl) begin
        en_reg <= bus.writedata[0];
      end
      if (bus.memread) begin
        sel_ram_reg <= is_ram;
        io_rd_reg   <= io_rdata;
      end
    end
  end

  assign bus.memdata = sel_ram_reg ? ram_rd_reg : io_rd_reg;
  assign led         = led_reg;
  assign tmr_irq     = match_reg;

endmodule

// File: tb/tb_dmem_bus.sv
// Directed bench for dmem_bus: RAM, read-before-write, LED/SW, timer match,
// priority collisions and asynchronous reset in the middle of an access.
module tb_dmem_bus;

  localparam logic [31:0] LED_A  = 32'hFFFF_0000;
  localparam logic [31:0] SW_A   = 32'hFFFF_0004;
  localparam logic [31:0] TCNT_A = 32'hFFFF_0008;
  localparam logic [31:0] TCMP_A = 32'hFFFF_000C;
  localparam logic [31:0] TCTL_A = 32'hFFFF_0010;

  logic        clk;
  logic        reset;
  logic [15:0] sw;
  logic [15:0] led;
  logic        tmr_irq;
  int          checks;
  int          errors;

  dmem_bus_if #(.WIDTH(32)) bus ();

  dmem_bus #(.WIDTH(32), .RAMBITS(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .sw      (sw),
    .led     (led),
    .tmr_irq (tmr_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.adr = a; bus.writedata = d; bus.memwrite = 1'b1;
    @(posedge clk);
    #1;
    bus.memwrite = 1'b0;
    $display("write adr=%h data=%h", a, d);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] q);
    bus.adr = a; bus.memread = 1'b1;
    @(posedge clk);
    #1;
    bus.memread = 1'b0;
    q = bus.memdata;
    $display("read  adr=%h data=%h", a, q);
  endtask

  task automatic bus_rw(input logic [31:0] a, input logic [31:0] d, output logic [31:0] q);
    bus.adr = a; bus.writedata = d; bus.memread = 1'b1; bus.memwrite = 1'b1;
    @(posedge clk);
    #1;
    bus.memread = 1'b0; bus.memwrite = 1'b0;
    q = bus.memdata;
    $display("rdwr  adr=%h wdata=%h rdata=%h", a, d, q);
  endtask

  task automatic test_reset;
    logic [31:0] q;
    checks++; if (bus.memdata !== 32'h0) begin errors++; $display("FAIL rst_memdata: got %h want %h", bus.memdata, 32'h0); end
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL rst_led: got %h want %h", led, 16'h0); end
    checks++; if (tmr_irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", tmr_irq); end
    bus_read(TCMP_A, q);
    checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_tcmp: got %h want %h", q, 32'hFFFF_FFFF); end
    bus_read(TCNT_A, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL rst_tcnt: got %h want %h", q, 32'h0); end
    bus_read(TCTL_A, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL rst_tctl: got %h want %h", q, 32'h0); end
  endtask

  task automatic test_ram;
    logic [31:0] q;
    bus_write(32'h0000_0010, 32'hDEAD_BEEF);
    bus_read(32'h0000_0013, q);
    checks++; if (q !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd: got %h want %h", q, 32'hDEAD_BEEF); end
    bus.adr = 32'h0000_0400;
    idle(2);
    checks++; if (bus.memdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_hold: got %h want %h", bus.memdata, 32'hDEAD_BEEF); end
    bus_read(32'h0000_0400, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL unmapped_rd: got %h want %h", q, 32'h0); end
    bus_write(32'h0000_03FC, 32'hCAFE_F00D);
    bus_read(32'h0000_03FC, q);
    checks++; if (q !== 32'hCAFE_F00D) begin errors++; $display("FAIL ram_top: got %h want %h", q, 32'hCAFE_F00D); end
    bus_read(32'h0000_0010, q);
    checks++; if (q !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_alias: got %h want %h", q, 32'hDEAD_BEEF); end
  endtask

  task automatic test_read_before_write;
    logic [31:0] q;
    bus_write(32'h0000_0020, 32'h11);
    bus_rw(32'h0000_0020, 32'h22, q);
    checks++; if (q !== 32'h11) begin errors++; $display("FAIL rbw_old: got %h want %h", q, 32'h11); end
    bus_read(32'h0000_0020, q);
    checks++; if (q !== 32'h22) begin errors++; $display("FAIL rbw_new: got %h want %h", q, 32'h22); end
  endtask

  task automatic test_io;
    logic [31:0] q;
    bus_write(LED_A, 32'h1234_ABCD);
    checks++; if (led !== 16'hABCD) begin errors++; $display("FAIL led_out: got %h want %h", led, 16'hABCD); end
    bus_read(LED_A, q);
    checks++; if (q !== 32'h0000_ABCD) begin errors++; $display("FAIL led_rd: got %h want %h", q, 32'h0000_ABCD); end
    bus_read(LED_A | 32'h2, q);
    checks++; if (q !== 32'h0000_ABCD) begin errors++; $display("FAIL led_lsb_ignored: got %h want %h", q, 32'h0000_ABCD); end
    sw = 16'h5A5A;
    idle(3);
    bus_read(SW_A, q);
    checks++; if (q !== 32'h0000_5A5A) begin errors++; $display("FAIL sw_rd: got %h want %h", q, 32'h0000_5A5A); end
    bus_write(SW_A, 32'h0000_FFFF);
    bus_read(SW_A, q);
    checks++; if (q !== 32'h0000_5A5A) begin errors++; $display("FAIL sw_ro: got %h want %h", q, 32'h0000_5A5A); end
    bus_write(32'hFFFF_0014, 32'h77);
    bus_read(32'hFFFF_0014, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL io_unmapped: got %h want %h", q, 32'h0); end
  endtask

  task automatic test_timer_match;
    logic [31:0] q;
    logic [31:0] exp_cnt [5];
    logic        exp_irq [5];
    exp_cnt[0] = 32'd0; exp_cnt[1] = 32'd1; exp_cnt[2] = 32'd2; exp_cnt[3] = 32'd3; exp_cnt[4] = 32'd0;
    exp_irq[0] = 1'b0;  exp_irq[1] = 1'b0;  exp_irq[2] = 1'b0;  exp_irq[3] = 1'b1;  exp_irq[4] = 1'b1;
    bus_write(TCMP_A, 32'd3);
    bus_write(TCNT_A, 32'd0);
    bus_write(TCTL_A, 32'd1);
    bus.adr = TCNT_A; bus.memread = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++; if (bus.memdata !== exp_cnt[i]) begin errors++; $display("FAIL tcnt_seq[%0d]: got %h want %h", i, bus.memdata, exp_cnt[i]); end
      checks++; if (tmr_irq !== exp_irq[i]) begin errors++; $display("FAIL irq_seq[%0d]: got %b want %b", i, tmr_irq, exp_irq[i]); end
    end
    bus.memread = 1'b0;
    bus_write(TCTL_A, 32'd3);
    checks++; if (tmr_irq !== 1'b0) begin errors++; $display("FAIL match_clear: got %b want 0", tmr_irq); end
    bus_read(TCTL_A, q);
    checks++; if (q !== 32'd1) begin errors++; $display("FAIL tctl_after_clear: got %h want %h", q, 32'd1); end
  endtask

  task automatic test_collisions;
    logic [31:0] q;
    bus_write(TCTL_A, 32'd2);
    bus_write(TCNT_A, 32'd0);
    bus_write(TCMP_A, 32'd2);
    bus_write(TCTL_A, 32'd1);
    idle(2);
    bus_write(TCNT_A, 32'd100);
    checks++; if (tmr_irq !== 1'b1) begin errors++; $display("FAIL tcnt_wr_match_irq: got %b want 1", tmr_irq); end
    bus_read(TCNT_A, q);
    checks++; if (q !== 32'd100) begin errors++; $display("FAIL tcnt_wr_override: got %h want %h", q, 32'd100); end
    bus_write(TCTL_A, 32'd2);
    checks++; if (tmr_irq !== 1'b0) begin errors++; $display("FAIL disable_clear: got %b want 0", tmr_irq); end
    bus_write(TCNT_A, 32'd0);
    idle(3);
    bus_read(TCNT_A, q);
    checks++; if (q !== 32'd0) begin errors++; $display("FAIL en0_hold: got %h want %h", q, 32'd0); end
    bus_write(TCTL_A, 32'd1);
    idle(2);
    bus_write(TCTL_A, 32'd3);
    checks++; if (tmr_irq !== 1'b1) begin errors++; $display("FAIL set_beats_clear: got %b want 1", tmr_irq); end
    bus_read(TCTL_A, q);
    checks++; if (q !== 32'd3) begin errors++; $display("FAIL tctl_after_collide: got %h want %h", q, 32'd3); end
  endtask

  task automatic test_wrap;
    bus_write(TCTL_A, 32'd2);
    bus_write(TCMP_A, 32'd5);
    bus_write(TCNT_A, 32'hFFFF_FFFF);
    bus_write(TCTL_A, 32'd1);
    bus.adr = TCNT_A; bus.memread = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.memdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_pre: got %h want %h", bus.memdata, 32'hFFFF_FFFF); end
    @(posedge clk);
    #1;
    bus.memread = 1'b0;
    checks++; if (bus.memdata !== 32'h0) begin errors++; $display("FAIL wrap_post: got %h want %h", bus.memdata, 32'h0); end
    checks++; if (tmr_irq !== 1'b0) begin errors++; $display("FAIL wrap_no_match: got %b want 0", tmr_irq); end
  endtask

  task automatic test_async_reset;
    logic [31:0] q;
    bus_write(LED_A, 32'h0000_FFFF);
    idle(4);
    checks++; if (tmr_irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b want 1", tmr_irq); end
    bus_read(TCTL_A, q);
    checks++; if (q !== 32'd3) begin errors++; $display("FAIL pre_reset_tctl: got %h want %h", q, 32'd3); end
    bus.adr = 32'h0000_0010; bus.writedata = 32'h55; bus.memwrite = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL async_led: got %h want %h", led, 16'h0); end
    checks++; if (tmr_irq !== 1'b0) begin errors++; $display("FAIL async_irq: got %b want 0", tmr_irq); end
    checks++; if (bus.memdata !== 32'h0) begin errors++; $display("FAIL async_memdata: got %h want %h", bus.memdata, 32'h0); end
    @(posedge clk);
    #1;
    bus.memwrite = 1'b0;
    reset = 1'b1;
    idle(1);
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL post_reset_led: got %h want %h", led, 16'h0); end
    bus_read(TCNT_A, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL post_reset_tcnt: got %h want %h", q, 32'h0); end
    bus_read(32'h0000_0010, q);
    checks++; if (q !== 32'hDEAD_BEEF) begin errors++; $display("FAIL no_partial_write: got %h want %h", q, 32'hDEAD_BEEF); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    sw = 16'h0;
    bus.memread = 1'b0; bus.memwrite = 1'b0;
    bus.adr = 32'h0; bus.writedata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    test_reset();
    test_ram();
    test_read_before_write();
    test_io();
    test_timer_match();
    test_collisions();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
